systolic_feed_controller: RTL and testbench

//  Sequences one matrix pass through the systolic data-setup (diagonal skew) stage feeding the vTPU array.
//  On start: issues row reads to the unified buffer, then shifts the skew stage once per returned row.

---
 rtl/systolic_feed_controller.sv | 132 +++++++++++++
 tb/tb_systolic_feed_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_controller.sv
// Feeds one matrix pass from the unified buffer through the diagonal skew stage into the array,
// then flushes the skew stage with zero rows. Optional stall counter enabled by SETUP_PERF_EN.
module systolic_feed_controller #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  parameter int LEN_WIDTH    = 32,
  parameter int BUF_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_count,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  setup_enable,
  output logic                  setup_zero_fill
`ifdef SETUP_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int FLUSH_W    = (MATRIX_WIDTH > 2) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int FLUSH_LAST = (MATRIX_WIDTH > 1) ? MATRIX_WIDTH - 2 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LEN_WIDTH-1:0]   count_q;
  logic [LEN_WIDTH-1:0]   issued_q;
  logic [FLUSH_W-1:0]     flush_q;
  logic [BUF_LATENCY-1:0] valid_q, valid_d;
  logic                   accept, rd_fire, flush_step, flush_last;

  assign accept     = (state_q == IDLE) && start;
  assign rd_fire    = (state_q == FEED) && !stall && (issued_q < count_q);
  assign flush_step = (state_q == FLUSH) && !stall;
  assign flush_last = (flush_q == FLUSH_W'(FLUSH_LAST));

  // Each read lands in the skew stage exactly BUF_LATENCY cycles later; stall never touches this.
  assign valid_d = (valid_q << 1) | BUF_LATENCY'(rd_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      flush_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (accept) begin
        base_q   <= base_addr;
        count_q  <= row_count;
        issued_q <= '0;
        flush_q  <= '0;
      end else begin
        if (rd_fire) begin
          issued_q <= issued_q + 1'b1;
        end
        if (flush_step) begin
          flush_q <= flush_q + 1'b1;
        end
      end
    end
  end

  // Leave FEED in the cycle the last row drains so the first flush step follows with no gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (row_count == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if ((issued_q == count_q) && (valid_d == '0)) begin
          state_d = (MATRIX_WIDTH > 1) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        if (flush_step && flush_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy            = (state_q == FEED) || (state_q == FLUSH);
    done            = (state_q == DONE);
    buf_rd_en       = rd_fire;
    buf_rd_addr     = '0;
    setup_enable    = valid_q[BUF_LATENCY-1] | flush_step;
    setup_zero_fill = flush_step;
    if (rd_fire) begin
      buf_rd_addr = base_q + ADDR_WIDTH'(issued_q);
    end
  end

`ifdef SETUP_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_stall_cycles <= '0;
    end else if (busy && stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Directed self-checking bench for systolic_feed_controller (default parameters).
module tb_systolic_feed_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] base_addr;
  logic [31:0] row_count;
  logic        stall;
  logic        busy;
  logic        done;
  logic        buf_rd_en;
  logic [23:0] buf_rd_addr;
  logic        setup_enable;
  logic        setup_zero_fill;
`ifdef SETUP_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  int          n_reads, n_data_en, n_flush_en, done_cyc;
  int          first_read, last_read, first_en, illegal;
  logic        busy_at1, busy_at_done, busy_after, done_after;
  logic [23:0] addr_q[$];

  systolic_feed_controller #(
    .MATRIX_WIDTH(14),
    .ADDR_WIDTH  (24),
    .LEN_WIDTH   (32),
    .BUF_LATENCY (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .row_count      (row_count),
    .stall          (stall),
    .busy           (busy),
    .done           (done),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .setup_enable   (setup_enable),
    .setup_zero_fill(setup_zero_fill)
`ifdef SETUP_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One pass: start at cycle 0, stall over [stall_from, stall_from+stall_len), extra start pulse at restart_at.
  task automatic applyStimulus(input logic [23:0] b, input logic [31:0] n, input int stall_from,
                               input int stall_len, input int restart_at);
    n_reads = 0; n_data_en = 0; n_flush_en = 0; done_cyc = -1;
    first_read = -1; last_read = -1; first_en = -1; illegal = 0;
    busy_at1 = 1'b0; busy_at_done = 1'b1;
    addr_q.delete();
    @(posedge clk); #1;
    for (int t = 0; t < 300 && done_cyc < 0; t++) begin
      start     = (t == 0) || (t == restart_at);
      base_addr = b;
      row_count = n;
      stall     = (t >= stall_from) && (t < stall_from + stall_len);
      @(negedge clk);
      if (buf_rd_en) begin
        n_reads++;
        addr_q.push_back(buf_rd_addr);
        if (first_read < 0) first_read = t;
        last_read = t;
      end
      if (setup_enable && !setup_zero_fill) begin
        n_data_en++;
        if (first_en < 0) first_en = t;
      end
      if (setup_enable && setup_zero_fill) n_flush_en++;
      if (setup_zero_fill && (buf_rd_en || !busy)) illegal++;
      if (t == 1) busy_at1 = busy;
      if (done) begin
        done_cyc     = t;
        busy_at_done = busy;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    busy_after = busy;
    done_after = done;
    checkOutput("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; row_count = '0; stall = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_en", 32'(buf_rd_en), 32'd0);
    checkOutput("rst_addr", 32'(buf_rd_addr), 32'd0);
    checkOutput("rst_en", 32'(setup_enable), 32'd0);
    checkOutput("rst_zf", 32'(setup_zero_fill), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Basic pass; a start pulse in the DONE cycle must be ignored.
    applyStimulus(24'h10, 32'd3, 1000, 0, 19);
    checkOutput("t1_reads", 32'(n_reads), 32'd3);
    checkOutput("t1_addr0", 32'(addr_q[0]), 32'h10);
    checkOutput("t1_addr1", 32'(addr_q[1]), 32'h11);
    checkOutput("t1_addr2", 32'(addr_q[2]), 32'h12);
    checkOutput("t1_first_read", 32'(first_read), 32'd1);
    checkOutput("t1_last_read", 32'(last_read), 32'd3);
    checkOutput("t1_data_en", 32'(n_data_en), 32'd3);
    checkOutput("t1_first_en", 32'(first_en), 32'd3);
    checkOutput("t1_flush_en", 32'(n_flush_en), 32'd13);
    checkOutput("t1_done_cyc", 32'(done_cyc), 32'd19);
    checkOutput("t1_busy_at1", 32'(busy_at1), 32'd1);
    checkOutput("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("t1_start_in_done", 32'(busy_after), 32'd0);
    checkOutput("t1_done_pulse", 32'(done_after), 32'd0);
    checkOutput("t1_illegal", 32'(illegal), 32'd0);

    // Zero-length pass.
    applyStimulus(24'h20, 32'd0, 1000, 0, -1);
    checkOutput("t2_done_cyc", 32'(done_cyc), 32'd1);
    checkOutput("t2_reads", 32'(n_reads), 32'd0);
    checkOutput("t2_data_en", 32'(n_data_en + n_flush_en), 32'd0);

    // Stall for three cycles right after the second read.
    applyStimulus(24'h30, 32'd4, 3, 3, -1);
    checkOutput("t3_reads", 32'(n_reads), 32'd4);
    checkOutput("t3_addr3", 32'(addr_q[3]), 32'h33);
    checkOutput("t3_data_en", 32'(n_data_en), 32'd4);
    checkOutput("t3_flush_en", 32'(n_flush_en), 32'd13);
    checkOutput("t3_done_cyc", 32'(done_cyc), 32'd23);
`ifdef SETUP_PERF_EN
    checkOutput("t3_perf", perf_stall_cycles, 32'd3);
`endif

    // Stall for five cycles in the middle of the flush.
    applyStimulus(24'h50, 32'd3, 8, 5, -1);
    checkOutput("t4_data_en", 32'(n_data_en), 32'd3);
    checkOutput("t4_flush_en", 32'(n_flush_en), 32'd13);
    checkOutput("t4_done_cyc", 32'(done_cyc), 32'd24);
    checkOutput("t4_illegal", 32'(illegal), 32'd0);
`ifdef SETUP_PERF_EN
    checkOutput("t4_perf", perf_stall_cycles, 32'd5);
`endif

    // Address wrap-around.
    applyStimulus(24'hFFFFFE, 32'd4, 1000, 0, -1);
    checkOutput("t5_reads", 32'(n_reads), 32'd4);
    checkOutput("t5_addr0", 32'(addr_q[0]), 32'hFFFFFE);
    checkOutput("t5_addr1", 32'(addr_q[1]), 32'hFFFFFF);
    checkOutput("t5_addr2", 32'(addr_q[2]), 32'h000000);
    checkOutput("t5_addr3", 32'(addr_q[3]), 32'h000001);
    checkOutput("t5_done_cyc", 32'(done_cyc), 32'd20);

    // Reset asserted mid-FEED, stalled so the perf counter has something to clear.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 24'h40; row_count = 32'd5; stall = 1'b0;
    @(posedge clk); #1 start = 1'b0; stall = 1'b1;
    @(posedge clk); #1 stall = 1'b0;
    #1;
    checkOutput("t6_pre_busy", 32'(busy), 32'd1);
    checkOutput("t6_pre_rd_en", 32'(buf_rd_en), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_rd_en", 32'(buf_rd_en), 32'd0);
    checkOutput("t6_addr", 32'(buf_rd_addr), 32'd0);
    checkOutput("t6_en", 32'(setup_enable), 32'd0);
    checkOutput("t6_zf", 32'(setup_zero_fill), 32'd0);
`ifdef SETUP_PERF_EN
    checkOutput("t6_perf", perf_stall_cycles, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b1;
    begin
      int dones = 0;
      int ens = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (done) dones++;
        if (setup_enable || buf_rd_en) ens++;
      end
      checkOutput("t6_no_done", 32'(dones), 32'd0);
      checkOutput("t6_no_activity", 32'(ens), 32'd0);
    end

    applyStimulus(24'h80, 32'd2, 1000, 0, -1);
    checkOutput("t7_reads", 32'(n_reads), 32'd2);
    checkOutput("t7_addr0", 32'(addr_q[0]), 32'h80);
    checkOutput("t7_addr1", 32'(addr_q[1]), 32'h81);
    checkOutput("t7_data_en", 32'(n_data_en), 32'd2);
    checkOutput("t7_flush_en", 32'(n_flush_en), 32'd13);
    checkOutput("t7_done_cyc", 32'(done_cyc), 32'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
